// File: rtl/tlc_dir_scheduler_if.sv
// Scheduler <-> combiner/sensor bundle: sensor requests and combiner ok in, direction grant and status out.
// The scheduler connects through the master modport; its environment uses slave.
interface tlc_dir_scheduler_if;
  logic [2:0] req;
  logic       ok;
  logic [1:0] dir;
  logic [2:0] pending;
  logic       busy;
  logic       served;
  logic       tmo;

  modport master (
    input  req, ok,
    output dir, pending, busy, served, tmo
  );

  modport slave (
    output req, ok,
    input  dir, pending, busy, served, tmo
  );
endinterface

// File: rtl/tlc_dir_scheduler.sv
// Round-robin NS/EW/LT request scheduler; grant one cycle after pending is seen, held until an armed ok.
// Define TLC_SCHED_TIMEOUT_EN to abandon a grant after TIMEOUT SERVE cycles without a retire.
module tlc_dir_scheduler #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input logic               clk,
  input logic               rst,
  tlc_dir_scheduler_if.master bus
);

  localparam logic [1:0] M_NS = 2'd0;
  localparam logic [1:0] M_EW = 2'd1;
  localparam logic [1:0] M_LT = 2'd2;

  if (TIMEOUT >= (1 << TW)) begin : g_cfg_check
    $error("tlc_dir_scheduler: TW too narrow for TIMEOUT");
  end

  typedef enum logic {IDLE, SERVE} state_t;

  state_t     state_q, state_nxt;
  logic [1:0] dir_q, dir_nxt;
  logic [1:0] rr_q, rr_nxt;
  logic [2:0] pending_q, pending_nxt;
  logic       busy_q, busy_nxt;
  logic       served_q, served_nxt;
  logic       armed_q, armed_nxt;
  logic       retire, abandon;
  logic [1:0] pick, scan_idx;
  logic       pick_vld;

  function automatic logic [1:0] nxt_dir(input logic [1:0] d);
    case (d)
      M_NS:    return M_EW;
      M_EW:    return M_LT;
      default: return M_NS;
    endcase
  endfunction

  // State register plus the registered outputs computed below.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= M_NS;
      rr_q      <= M_NS;
      pending_q <= 3'b000;
      busy_q    <= 1'b0;
      served_q  <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      dir_q     <= dir_nxt;
      rr_q      <= rr_nxt;
      pending_q <= pending_nxt;
      busy_q    <= busy_nxt;
      served_q  <= served_nxt;
      armed_q   <= armed_nxt;
    end
  end

  always_comb begin
    scan_idx = rr_q;
    pick     = rr_q;
    pick_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!pick_vld && pending_q[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
      scan_idx = nxt_dir(scan_idx);
    end
  end

  // armed filters an ok left high from the previous grant of the same direction.
  assign retire = (state_q == SERVE) && armed_q && bus.ok;

`ifdef TLC_SCHED_TIMEOUT_EN
  logic [TW-1:0] cnt_q;
  logic          tmo_q;

  assign abandon = (state_q == SERVE) && !retire && (cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= abandon;
      if (state_q == IDLE)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.tmo = tmo_q;
`else
  assign abandon = 1'b0;
  assign bus.tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_nxt = SERVE;
      SERVE:   if (retire || abandon) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dir_nxt     = dir_q;
    rr_nxt      = rr_q;
    armed_nxt   = armed_q;
    served_nxt  = retire;
    busy_nxt    = (state_nxt == SERVE);
    // A request on the retiring cycle re-sets the bit being cleared.
    pending_nxt = (pending_q & ~(retire ? (3'b001 << dir_q) : 3'b000)) | bus.req;
    if (state_q == IDLE) begin
      if (pick_vld) begin
        dir_nxt   = pick;
        armed_nxt = 1'b0;
      end
    end else begin
      armed_nxt = armed_q | ~bus.ok;
      if (retire || abandon)
        rr_nxt = nxt_dir(dir_q);
    end
  end

  assign bus.dir     = dir_q;
  assign bus.pending = pending_q;
  assign bus.busy    = busy_q;
  assign bus.served  = served_q;

endmodule

// File: tb/tb_tlc_dir_scheduler.sv
// Directed and random checks of tlc_dir_scheduler against a cycle-level reference model of its rules.
module tb_tlc_dir_scheduler;
`ifdef TLC_SCHED_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlc_dir_scheduler_if bus();

  tlc_dir_scheduler #(.TIMEOUT(TB_TIMEOUT), .TW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int       m_dir, m_rr, m_cnt;
  bit [2:0] m_pend;
  bit       m_busy, m_served, m_tmo, m_armed;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(bit r_rst, bit [2:0] r, bit o);
    bit [2:0] np;
    int idx;
    if (r_rst) begin
      m_dir = 0; m_rr = 0; m_cnt = 0; m_pend = 0;
      m_busy = 0; m_served = 0; m_tmo = 0; m_armed = 0;
      return;
    end
    np = m_pend | r;
    m_served = 0;
    m_tmo = 0;
    if (!m_busy) begin
      if (m_pend != 0) begin
        idx = m_rr;
        for (int k = 0; k < 3; k++) begin
          idx = (m_rr + k) % 3;
          if (m_pend[idx]) break;
        end
        m_dir = idx; m_busy = 1; m_armed = 0; m_cnt = 0;
      end
    end else if (m_armed && o) begin
      if (!r[m_dir]) np[m_dir] = 1'b0;
      m_served = 1;
      m_rr = (m_dir + 1) % 3;
      m_busy = 0;
    end else begin
      if (!o) m_armed = 1;
`ifdef TLC_SCHED_TIMEOUT_EN
      if (m_cnt + 1 == TB_TIMEOUT) begin
        m_tmo = 1;
        m_rr = (m_dir + 1) % 3;
        m_busy = 0;
      end else begin
        m_cnt++;
      end
`endif
    end
    m_pend = np;
  endtask

  task automatic cyc(bit r_rst, bit [2:0] r, bit o);
    rst = r_rst;
    bus.req = r;
    bus.ok = o;
    @(posedge clk);
    model_step(r_rst, r, o);
    #1;
    chk("dir", bus.dir, m_dir);
    chk("pending", bus.pending, m_pend);
    chk("busy", bus.busy, m_busy);
    chk("served", bus.served, m_served);
    chk("tmo", bus.tmo, m_tmo);
  endtask

  initial begin
    int srv_dirs[$];
    int nsrv;
    bit [2:0] rq;

    // reset with all requests asserted
    cyc(1, 3'b111, 0);
    cyc(1, 3'b111, 0);
    chk("rst_dir", bus.dir, 0);
    chk("rst_pend", bus.pending, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_served", bus.served, 0);
    cyc(0, 3'b111, 0);
    chk("post_rst_pend", bus.pending, 3'b111);

    // round robin over all three
    for (int i = 0; i < 12; i++) begin
      cyc(0, 3'b000, bit'(i % 2));
      if (bus.served === 1'b1) srv_dirs.push_back(int'(bus.dir));
    end
    chk("rr_count", srv_dirs.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("rr_dir", (i < srv_dirs.size()) ? srv_dirs[i] : 9, i);
    chk("rr_pend", bus.pending, 0);

    // single EW request
    cyc(0, 3'b010, 0);
    cyc(0, 3'b000, 0);
    chk("single_dir", bus.dir, 1);
    chk("single_busy", bus.busy, 1);
    cyc(0, 3'b000, 0);
    cyc(0, 3'b000, 1);
    chk("single_served", bus.served, 1);
    chk("single_pend", bus.pending, 0);
    chk("single_idle", bus.busy, 0);

    // stale ok guard on NS re-grant
    cyc(0, 3'b001, 0);
    cyc(0, 3'b000, 0);
    chk("stale_first_dir", bus.dir, 0);
    cyc(0, 3'b000, 0);
    cyc(0, 3'b000, 1);
    chk("stale_first_served", bus.served, 1);
    nsrv = 0;
    cyc(0, 3'b001, 1); nsrv += int'(bus.served);
    cyc(0, 3'b000, 1); nsrv += int'(bus.served);
    chk("stale_regrant", bus.busy, 1);
    cyc(0, 3'b000, 1); nsrv += int'(bus.served);
    cyc(0, 3'b000, 1); nsrv += int'(bus.served);
    chk("stale_held", nsrv, 0);
    cyc(0, 3'b000, 0); nsrv += int'(bus.served);
    cyc(0, 3'b000, 1); nsrv += int'(bus.served);
    chk("stale_served_once", nsrv, 1);

    // set wins over retire clear
    cyc(0, 3'b001, 0);
    cyc(0, 3'b000, 0);
    cyc(0, 3'b000, 0);
    cyc(0, 3'b001, 1);
    chk("setwins_served", bus.served, 1);
    chk("setwins_pend", bus.pending, 3'b001);
    cyc(0, 3'b000, 0);
    chk("setwins_regrant_dir", bus.dir, 0);
    chk("setwins_regrant_busy", bus.busy, 1);
    cyc(0, 3'b000, 0);
    cyc(0, 3'b000, 1);

    // reset during SERVE
    cyc(0, 3'b100, 0);
    cyc(0, 3'b000, 0);
    chk("mid_grant_dir", bus.dir, 2);
    cyc(0, 3'b011, 0);
    cyc(1, 3'b000, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_pend", bus.pending, 0);
    chk("mid_rst_dir", bus.dir, 0);
    cyc(0, 3'b000, 0);

`ifdef TLC_SCHED_TIMEOUT_EN
    cyc(0, 3'b010, 0);
    cyc(0, 3'b000, 0);
    chk("tmo_grant_dir", bus.dir, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 3'b000, 0);
      chk("tmo_early", bus.tmo, 0);
    end
    cyc(0, 3'b000, 0);
    chk("tmo_pulse", bus.tmo, 1);
    chk("tmo_pend_kept", bus.pending, 3'b010);
    chk("tmo_busy", bus.busy, 0);
    cyc(0, 3'b000, 0);
    chk("tmo_regrant_dir", bus.dir, 1);
    chk("tmo_regrant_busy", bus.busy, 1);
    cyc(0, 3'b000, 0);
    cyc(0, 3'b000, 1);
`endif

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rq = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      cyc(($urandom_range(0, 149) == 0), rq, bit'($urandom_range(0, 1)));
      chk("dir_legal", (bus.dir != 2'd3), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
